fwd_hazard_unit: RTL and testbench

Parametrised forwarding and load-use hazard unit for the RV32 pipeline. It owns a registered tag pipeline of in-flight destination registers, one entry per post-EX stage. Each cycle it compares every EX source operand against that pipeline and drives per-source bypass-mux selects. It also asserts a pipeline stall when a source depends on a load whose data is not yet available, and optionally counts stall activity.

---
 rtl/hazard_pkg.sv | 24 ++
 rtl/fwd_hazard_unit_if.sv | 38 +++
 rtl/fwd_tag_pipe.sv | 40 ++++
 rtl/fwd_hazard_unit.sv | 113 +++++++++++
 tb/tb_fwd_hazard_unit.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// Shared types and helpers for the forwarding / load-use hazard unit.
//   tag_entry_t : one in-flight destination tag {valid, rd, reg_write, is_load}
//   ep_state_t  : stall-episode state used by the optional perf counters
//   FWD_NONE    : fwd_sel value meaning "use the register-file operand"
//   sel_w()     : width of a per-source forward select for a given stage count
package hazard_pkg;
  localparam int FWD_NONE = 0;
  // rd is stored at this fixed width so the struct can live in the package;
  // REG_AW must not exceed it (zero-extended on entry).
  localparam int RD_MAX_W = 8;

  typedef struct packed {
    logic                valid;
    logic [RD_MAX_W-1:0] rd;
    logic                reg_write;
    logic                is_load;
  } tag_entry_t;

  typedef enum logic {RUN = 1'b0, STALLED = 1'b1} ep_state_t;

  function automatic int sel_w(input int num_stages);
    return $clog2(num_stages + 1);
  endfunction
endpackage

// File: rtl/fwd_hazard_unit_if.sv
// Bus between the ID/EX stage and the hazard unit.
//   master : ID/EX side, drives the instruction fields and flush, reads
//            fwd_sel / stall / perf counters
//   slave  : hazard unit
interface fwd_hazard_unit_if
  import hazard_pkg::*;
#(
  parameter int NUM_SRC    = 2,
  parameter int NUM_STAGES = 2,
  parameter int REG_AW     = 5,
  parameter int CNT_W      = 32
);
  localparam int SEL_W = sel_w(NUM_STAGES);

  logic                      id_ex_valid;
  logic [NUM_SRC*REG_AW-1:0] id_ex_rs;
  logic [NUM_SRC-1:0]        id_ex_rs_used;
  logic [REG_AW-1:0]         id_ex_rd;
  logic                      id_ex_reg_write;
  logic                      id_ex_is_load;
  logic                      flush;
  logic [NUM_SRC*SEL_W-1:0]  fwd_sel;
  logic                      stall;
  logic [CNT_W-1:0]          stall_cycles;
  logic [CNT_W-1:0]          stall_events;

  modport master (
    output id_ex_valid, id_ex_rs, id_ex_rs_used, id_ex_rd, id_ex_reg_write,
           id_ex_is_load, flush,
    input  fwd_sel, stall, stall_cycles, stall_events
  );

  modport slave (
    input  id_ex_valid, id_ex_rs, id_ex_rs_used, id_ex_rd, id_ex_reg_write,
           id_ex_is_load, flush,
    output fwd_sel, stall, stall_cycles, stall_events
  );
endinterface

// File: rtl/fwd_tag_pipe.sv
// Registered shift pipeline of in-flight destination tags, one entry per
// post-EX stage (entry 1 = EX/MEM, entry NUM_STAGES = oldest).
//   clk, rst  : clock, async active-high reset (all entries invalid)
//   in_valid  : ID/EX holds a real instruction
//   stall     : ID/EX is held this cycle -> bubble into entry 1
//   flush     : ID/EX is killed this cycle -> bubble into entry 1
//   in_tag    : tag of the ID/EX instruction
//   tags      : current entries 1..NUM_STAGES
module fwd_tag_pipe
  import hazard_pkg::*;
#(
  parameter int NUM_STAGES = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic                        stall,
  input  logic                        flush,
  input  tag_entry_t                  in_tag,
  output tag_entry_t [NUM_STAGES:1]   tags
);
  tag_entry_t [NUM_STAGES:1] tag_q, tag_d;

  always_comb begin
    tag_d    = tag_q;
    tag_d[1] = '0;
    if (in_valid && !stall && !flush) begin
      tag_d[1]       = in_tag;
      tag_d[1].valid = 1'b1;
    end
    for (int k = 2; k <= NUM_STAGES; k++) tag_d[k] = tag_q[k-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tag_q <= '0;
    else     tag_q <= tag_d;
  end

  assign tags = tag_q;
endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit for the RV32 pipeline.
//   clk, rst : clock, async active-high reset
//   bus      : fwd_hazard_unit_if.slave (ID/EX fields in; fwd_sel, stall,
//              stall_cycles, stall_events out)
// fwd_sel/stall are combinational from the registered tags and the current
// ID/EX fields. Build option HAZARD_PERF_EN adds saturating stall_cycles /
// stall_events counters; without it both read 0.
module fwd_hazard_unit
  import hazard_pkg::*;
#(
  parameter int NUM_SRC    = 2,
  parameter int NUM_STAGES = 2,
  parameter int LOAD_STAGE = 2,
  parameter int REG_AW     = 5,
  parameter int CNT_W      = 32
) (
  input logic              clk,
  input logic              rst,
  fwd_hazard_unit_if.slave bus
);
  localparam int SEL_W = sel_w(NUM_STAGES);

  tag_entry_t                      in_tag;
  tag_entry_t [NUM_STAGES:1]       tags;
  logic [NUM_SRC-1:0]              load_use;
  logic [NUM_SRC-1:0][SEL_W-1:0]   fwd_sel_w;
  logic                            stall;

  always_comb begin
    in_tag           = '0;
    in_tag.valid     = bus.id_ex_valid;
    in_tag.rd        = RD_MAX_W'(bus.id_ex_rd);
    in_tag.reg_write = bus.id_ex_reg_write;
    in_tag.is_load   = bus.id_ex_is_load;
  end

  fwd_tag_pipe #(.NUM_STAGES(NUM_STAGES)) u_tags (
    .clk      (clk),
    .rst      (rst),
    .in_valid (bus.id_ex_valid),
    .stall    (stall),
    .flush    (bus.flush),
    .in_tag   (in_tag),
    .tags     (tags)
  );

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    logic [REG_AW-1:0] rs;
    logic [SEL_W-1:0]  sel;
    logic              hit_load;

    assign rs = bus.id_ex_rs[i*REG_AW +: REG_AW];

    // Scan oldest to youngest so the youngest match overwrites older ones.
    always_comb begin
      sel      = SEL_W'(FWD_NONE);
      hit_load = 1'b0;
      for (int k = NUM_STAGES; k >= 1; k--) begin
        if (tags[k].valid && tags[k].reg_write && tags[k].rd != '0 &&
            tags[k].rd == RD_MAX_W'(rs) && bus.id_ex_rs_used[i]) begin
          sel      = SEL_W'(k);
          hit_load = tags[k].is_load && (k < LOAD_STAGE);
        end
      end
    end

    assign load_use[i]  = hit_load;
    assign fwd_sel_w[i] = sel;
  end

  assign stall       = bus.id_ex_valid & ~bus.flush & (|load_use);
  assign bus.stall   = stall;
  assign bus.fwd_sel = fwd_sel_w;

`ifdef HAZARD_PERF_EN
  ep_state_t        state_q, state_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] stall_events_q, stall_events_d;

  always_comb begin
    state_d        = state_q;
    stall_cycles_d = stall_cycles_q;
    stall_events_d = stall_events_q;
    case (state_q)
      RUN: if (stall) begin
        state_d = STALLED;
        if (stall_events_q != '1) stall_events_d = stall_events_q + CNT_W'(1);
      end
      STALLED: if (!stall) state_d = RUN;
      default: state_d = RUN;
    endcase
    if (stall && stall_cycles_q != '1) stall_cycles_d = stall_cycles_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= RUN;
      stall_cycles_q <= '0;
      stall_events_q <= '0;
    end else begin
      state_q        <= state_d;
      stall_cycles_q <= stall_cycles_d;
      stall_events_q <= stall_events_d;
    end
  end

  assign bus.stall_cycles = stall_cycles_q;
  assign bus.stall_events = stall_events_q;
`else
  assign bus.stall_cycles = {CNT_W{1'b0}};
  assign bus.stall_events = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: directed vector table, reset corner cases and
// randomized traffic against an in-flight-instruction list model.
module tb_fwd_hazard_unit;
  import hazard_pkg::*;

  localparam int NSRC = 2;
  localparam int NS   = 2;
  localparam int LS   = 2;
  localparam int AW   = 5;
  localparam int CW   = 32;
  localparam int SW   = sel_w(NS);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fwd_hazard_unit_if #(.NUM_SRC(NSRC), .NUM_STAGES(NS), .REG_AW(AW), .CNT_W(CW)) bus ();

  fwd_hazard_unit #(
    .NUM_SRC(NSRC), .NUM_STAGES(NS), .LOAD_STAGE(LS), .REG_AW(AW), .CNT_W(CW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int pass_cnt = 0;
  int tot_cnt  = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    tot_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // current stimulus
  bit       in_v, in_rw, in_ld, in_fl;
  int       in_rs [NSRC];
  bit [1:0] in_used;
  int       in_rd;

  // model: list of in-flight instructions, index 0 = youngest (stage 1)
  typedef struct { bit v; int rd; bit rw; bit ld; } minst_t;
  minst_t hist[$];
  longint mcyc, mevt;
  bit     mprev;

  function automatic void model_eval(output int sel [NSRC], output bit st);
    bit hz = 0;
    for (int i = 0; i < NSRC; i++) begin
      sel[i] = 0;
      if (in_used[i]) begin
        for (int a = 0; a < hist.size(); a++) begin
          if (hist[a].v && hist[a].rw && hist[a].rd != 0 && hist[a].rd == in_rs[i]) begin
            sel[i] = a + 1;
            if (hist[a].ld && (a + 1) < LS) hz = 1;
            break;
          end
        end
      end
    end
    st = in_v && !in_fl && hz;
  endfunction

  function automatic void model_reset();
    hist.delete();
    mcyc = 0; mevt = 0; mprev = 0;
  endfunction

  function automatic longint exp_cnt(input longint v);
`ifdef HAZARD_PERF_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  task automatic drive();
    bus.id_ex_valid     = in_v;
    bus.id_ex_rs        = {in_rs[1][AW-1:0], in_rs[0][AW-1:0]};
    bus.id_ex_rs_used   = in_used;
    bus.id_ex_rd        = in_rd[AW-1:0];
    bus.id_ex_reg_write = in_rw;
    bus.id_ex_is_load   = in_ld;
    bus.flush           = in_fl;
  endtask

  task automatic settle();
    @(negedge clk);
    drive();
    #1;
  endtask

  // advance model to match the coming rising edge, then wait for it
  task automatic advance();
    int sel [NSRC];
    bit st;
    minst_t e;
    model_eval(sel, st);
    e.v = in_v && !st && !in_fl; e.rd = in_rd; e.rw = in_rw; e.ld = in_ld;
    hist.push_front(e);
    if (hist.size() > NS) void'(hist.pop_back());
    if (st && mcyc != 64'hFFFF_FFFF) mcyc++;
    if (st && !mprev && mevt != 64'hFFFF_FFFF) mevt++;
    mprev = st;
    @(posedge clk);
  endtask

  task automatic randomize_inputs(input int rmax);
    in_v    = ($urandom % 8) != 0;
    in_rs[0] = $urandom_range(0, rmax);
    in_rs[1] = $urandom_range(0, rmax);
    in_used = 2'($urandom);
    in_rd   = $urandom_range(0, rmax);
    in_rw   = ($urandom % 4) != 0;
    in_ld   = ($urandom % 3) == 0;
    in_fl   = ($urandom % 8) == 0;
  endtask

  function automatic int dsel(input int i);
    logic [NSRC*SW-1:0] f;
    f = bus.fwd_sel;
    return int'(f[i*SW +: SW]);
  endfunction

  typedef struct {
    bit v; int rs0; int rs1; bit [1:0] used; int rd; bit rw; bit ld; bit fl;
    int e0; int e1; bit est; int ecnt;
  } vec_t;

  function automatic vec_t mk(bit v, int rs0, int rs1, bit [1:0] used, int rd, bit rw,
                              bit ld, bit fl, int e0, int e1, bit est, int ecnt);
    vec_t t;
    t.v = v; t.rs0 = rs0; t.rs1 = rs1; t.used = used; t.rd = rd; t.rw = rw;
    t.ld = ld; t.fl = fl; t.e0 = e0; t.e1 = e1; t.est = est; t.ecnt = ecnt;
    return t;
  endfunction

  vec_t tbl [15];

  initial begin
    int sel [NSRC];
    bit st;

    //            v rs0 rs1 used rd rw ld fl  e0 e1 st cnt
    tbl[0]  = mk(1, 1, 2, 2'b11, 5,  1, 0, 0,  0, 0, 0, 0); // add x5
    tbl[1]  = mk(1, 5, 1, 2'b11, 6,  1, 0, 0,  1, 0, 0, 0); // sub x6,x5,x1
    tbl[2]  = mk(1, 0, 0, 2'b00, 5,  1, 0, 0,  0, 0, 0, 0); // add x5
    tbl[3]  = mk(1, 3, 4, 2'b11, 5,  1, 0, 0,  0, 0, 0, 0); // add x5
    tbl[4]  = mk(1, 5, 5, 2'b11, 9,  1, 0, 0,  1, 1, 0, 0); // youngest wins
    tbl[5]  = mk(1, 1, 2, 2'b11, 0,  1, 0, 0,  0, 0, 0, 0); // write x0
    tbl[6]  = mk(1, 0, 0, 2'b11, 10, 1, 0, 0,  0, 0, 0, 0); // use x0
    tbl[7]  = mk(1, 2, 3, 2'b11, 7,  1, 1, 0,  0, 0, 0, 0); // lw x7
    tbl[8]  = mk(1, 7, 7, 2'b11, 7,  1, 0, 0,  1, 1, 1, 0); // load-use stall
    tbl[9]  = mk(1, 7, 7, 2'b11, 7,  1, 0, 0,  2, 2, 0, 1); // bubble in stage 1
    tbl[10] = mk(1, 0, 0, 2'b00, 7,  1, 1, 0,  0, 0, 0, 1); // lw x7
    tbl[11] = mk(1, 1, 7, 2'b01, 11, 1, 0, 0,  0, 0, 0, 1); // rs2 unused
    tbl[12] = mk(1, 0, 0, 2'b00, 7,  1, 1, 0,  0, 0, 0, 1); // lw x7
    tbl[13] = mk(1, 7, 7, 2'b11, 7,  1, 0, 1,  1, 1, 0, 1); // flush wins
    tbl[14] = mk(1, 7, 7, 2'b11, 12, 1, 0, 0,  2, 2, 0, 1); // flush left bubble

    // reset with random inputs
    rst = 1'b1;
    randomize_inputs(31);
    drive();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sel0", dsel(0), 0);
    chk("rst_sel1", dsel(1), 0);
    chk("rst_stall", bus.stall, 0);
    chk("rst_cycles", longint'(bus.stall_cycles), 0);
    chk("rst_events", longint'(bus.stall_events), 0);
    @(negedge clk);
    rst = 1'b0;

    // first cycle after reset: random fields, no real instruction
    randomize_inputs(31);
    in_v = 1'b0;
    settle();
    chk("post_rst_sel0", dsel(0), 0);
    chk("post_rst_sel1", dsel(1), 0);
    chk("post_rst_stall", bus.stall, 0);
    chk("post_rst_cycles", longint'(bus.stall_cycles), 0);
    advance();

    // directed vector table
    for (int n = 0; n < 15; n++) begin
      in_v = tbl[n].v; in_rs[0] = tbl[n].rs0; in_rs[1] = tbl[n].rs1;
      in_used = tbl[n].used; in_rd = tbl[n].rd; in_rw = tbl[n].rw;
      in_ld = tbl[n].ld; in_fl = tbl[n].fl;
      settle();
      chk($sformatf("vec%0d_sel0", n), dsel(0), tbl[n].e0);
      chk($sformatf("vec%0d_sel1", n), dsel(1), tbl[n].e1);
      chk($sformatf("vec%0d_stall", n), bus.stall, tbl[n].est);
      chk($sformatf("vec%0d_cycles", n), longint'(bus.stall_cycles), exp_cnt(tbl[n].ecnt));
      chk($sformatf("vec%0d_events", n), longint'(bus.stall_events), exp_cnt(tbl[n].ecnt));
      advance();
    end

    // reset arriving mid-stall drops stall at once
    in_v = 1; in_rs[0] = 0; in_rs[1] = 0; in_used = 2'b00; in_rd = 7;
    in_rw = 1; in_ld = 1; in_fl = 0;
    settle();
    advance();
    in_rs[0] = 7; in_rs[1] = 7; in_used = 2'b11; in_rd = 9; in_ld = 0;
    settle();
    chk("midrst_pre_stall", bus.stall, 1);
    rst = 1'b1;
    #1;
    chk("midrst_stall", bus.stall, 0);
    chk("midrst_sel0", dsel(0), 0);
    chk("midrst_cycles", longint'(bus.stall_cycles), 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // randomized traffic on a small register set to provoke many hits
    for (int n = 0; n < 600; n++) begin
      randomize_inputs(3);
      settle();
      model_eval(sel, st);
      chk("rnd_sel0", dsel(0), sel[0]);
      chk("rnd_sel1", dsel(1), sel[1]);
      chk("rnd_stall", bus.stall, st);
      chk("rnd_cycles", longint'(bus.stall_cycles), exp_cnt(mcyc));
      chk("rnd_events", longint'(bus.stall_events), exp_cnt(mevt));
      advance();
    end

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
